// File: rtl/vsi_pkg.sv
// Shared types and widths for the receive-side message sink.
package vsi_pkg;

  localparam int unsigned VSI_LEN_W  = 16;
  localparam int unsigned VSI_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } sink_state_t;

endpackage

// File: rtl/rx_sink_ram.sv
// Simple dual-port byte RAM: synchronous write, registered read.
module rx_sink_ram
  import vsi_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = VSI_BYTE_W
) (
  input  logic              clk,
  input  logic              rst_h,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rx_message_sink.sv
// Receive-side message buffer: stores payload, checks length, hands one message to a reader.
// Optional payload checksum enabled by defining VSI_SINK_CHECKSUM_EN.
module rx_message_sink
  import vsi_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_h,
  input  logic                  hdr_en,
  input  logic [VSI_BYTE_W-1:0] hdr_flag,
  input  logic [VSI_LEN_W-1:0]  hdr_len,
  input  logic                  wr_rq,
  input  logic [VSI_LEN_W-1:0]  wr_addr,
  input  logic [VSI_BYTE_W-1:0] wr_data,
  output logic                  wr_rdy,
  input  logic                  end_msg,
  input  logic                  msg_right,
  input  logic                  msg_line,
  output logic                  msg_valid,
  output logic [VSI_BYTE_W-1:0] msg_flag,
  output logic [VSI_LEN_W-1:0]  msg_len,
  output logic                  msg_src,
  output logic [VSI_LEN_W-1:0]  msg_sum,
  input  logic                  msg_ack,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [VSI_BYTE_W-1:0] rd_data,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [ERR_W-1:0]      drop_cnt
);

  localparam int unsigned CNT_W = VSI_LEN_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

  sink_state_t state_q, state_d;

  logic [VSI_BYTE_W-1:0] hdr_flag_q;
  logic [VSI_LEN_W-1:0]  hdr_len_q;
  logic [CNT_W-1:0]      wr_count_q;
  logic                  oflow_q;
  logic                  rq_held_q;

  logic             wr_accept_c, recv_wr_c, in_range_c, store_c;
  logic             cnt_inc_c, oflow_eff_c, commit_ok_c;
  logic [CNT_W-1:0] cnt_next_c;
  logic             start_c, commit_c, err_c, drop_c, release_c;

  // One acknowledge per assertion of wr_rq; a held request is not re-accepted.
  assign wr_accept_c = wr_rq && !wr_rdy && !rq_held_q;
  assign recv_wr_c   = wr_accept_c && (state_q == ST_RECV);
  assign in_range_c  = ({1'b0, wr_addr} < DEPTH);
  assign store_c     = recv_wr_c && in_range_c;
  assign cnt_inc_c   = recv_wr_c && (wr_count_q != '1);
  assign cnt_next_c  = wr_count_q + CNT_W'(cnt_inc_c);
  assign oflow_eff_c = oflow_q || (recv_wr_c && !in_range_c);

  // Commit check sees a write accepted in the same cycle as end_msg.
  assign commit_ok_c = msg_right && !oflow_eff_c
                    && (cnt_next_c == {1'b0, hdr_len_q})
                    && ({1'b0, hdr_len_q} <= DEPTH);

  always_ff @(posedge clk) begin
    if (rst_h) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    commit_c  = 1'b0;
    err_c     = 1'b0;
    drop_c    = 1'b0;
    release_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hdr_en) begin
          start_c = 1'b1;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (end_msg) begin
          if (commit_ok_c) begin
            commit_c = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            err_c   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (hdr_en) begin
          err_c   = 1'b1;
          start_c = 1'b1;
        end
      end
      ST_DROP: begin
        if (end_msg) begin
          state_d = msg_valid ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (msg_ack) begin
          release_c = 1'b1;
          if (hdr_en) begin
            start_c = 1'b1;
            state_d = ST_RECV;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hdr_en) begin
          drop_c  = 1'b1;
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      wr_rdy     <= 1'b0;
      rq_held_q  <= 1'b0;
      hdr_flag_q <= '0;
      hdr_len_q  <= '0;
      wr_count_q <= '0;
      oflow_q    <= 1'b0;
      msg_valid  <= 1'b0;
      msg_flag   <= '0;
      msg_len    <= '0;
      msg_src    <= 1'b0;
      err_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      wr_rdy <= wr_accept_c;
      if (wr_accept_c) begin
        rq_held_q <= 1'b1;
      end else if (!wr_rq) begin
        rq_held_q <= 1'b0;
      end

      if (start_c) begin
        hdr_flag_q <= hdr_flag;
        hdr_len_q  <= hdr_len;
        wr_count_q <= '0;
        oflow_q    <= 1'b0;
      end else if (state_q == ST_RECV) begin
        wr_count_q <= cnt_next_c;
        oflow_q    <= oflow_eff_c;
      end

      if (commit_c) begin
        msg_valid <= 1'b1;
        msg_flag  <= hdr_flag_q;
        msg_len   <= hdr_len_q;
        msg_src   <= msg_line;
      end else if (release_c) begin
        msg_valid <= 1'b0;
      end

      if (err_c && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
      if (drop_c && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + ERR_W'(1);
      end
    end
  end

`ifdef VSI_SINK_CHECKSUM_EN
  logic [VSI_LEN_W-1:0] sum_q, sum_next_c;

  assign sum_next_c = sum_q + (store_c ? VSI_LEN_W'(wr_data) : '0);

  // Running modulo-2^16 sum of stored bytes, published on commit.
  always_ff @(posedge clk) begin
    if (rst_h) begin
      sum_q   <= '0;
      msg_sum <= '0;
    end else begin
      if (start_c) begin
        sum_q <= '0;
      end else if (store_c) begin
        sum_q <= sum_next_c;
      end
      if (commit_c) begin
        msg_sum <= sum_next_c;
      end
    end
  end
`else
  assign msg_sum = '0;
`endif

  rx_sink_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (VSI_BYTE_W)
  ) u_ram (
    .clk   (clk),
    .rst_h (rst_h),
    .we    (store_c),
    .waddr (wr_addr[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_rx_message_sink.sv
// Self-checking bench for rx_message_sink against a message-level reference model.
module tb_rx_message_sink;

  localparam int unsigned AW    = 4;
  localparam int unsigned EW    = 8;
  localparam int unsigned DEPTH = 2 ** AW;
`ifdef VSI_SINK_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_h = 1'b1;
  logic          hdr_en = 1'b0;
  logic [7:0]    hdr_flag = '0;
  logic [15:0]   hdr_len = '0;
  logic          wr_rq = 1'b0;
  logic [15:0]   wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_rdy;
  logic          end_msg = 1'b0;
  logic          msg_right = 1'b0;
  logic          msg_line = 1'b0;
  logic          msg_valid;
  logic [7:0]    msg_flag;
  logic [15:0]   msg_len;
  logic          msg_src;
  logic [15:0]   msg_sum;
  logic          msg_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic [EW-1:0] err_cnt;
  logic [EW-1:0] drop_cnt;

  rx_message_sink #(.ADDR_W(AW), .ERR_W(EW)) dut (
    .clk(clk), .rst_h(rst_h), .hdr_en(hdr_en), .hdr_flag(hdr_flag), .hdr_len(hdr_len),
    .wr_rq(wr_rq), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .end_msg(end_msg), .msg_right(msg_right), .msg_line(msg_line),
    .msg_valid(msg_valid), .msg_flag(msg_flag), .msg_len(msg_len), .msg_src(msg_src),
    .msg_sum(msg_sum), .msg_ack(msg_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: what a reader should see after each whole message.
  bit          m_valid;
  int          m_err, m_drop;
  logic [7:0]  m_flag;
  logic [15:0] m_len;
  bit          m_src;
  logic [15:0] m_sum;
  logic [7:0]  m_mem [DEPTH];
  bit          m_def [DEPTH];

  // Current message description.
  int          cur_len;
  logic [7:0]  cur_flag;
  bit          cur_right, cur_line;
  int unsigned q_addr [$];
  logic [7:0]  q_data [$];

  function automatic void model_reset();
    m_valid = 0; m_err = 0; m_drop = 0;
    m_flag = '0; m_len = '0; m_src = 0; m_sum = '0;
    for (int i = 0; i < DEPTH; i++) m_def[i] = 0;
  endfunction

  function automatic void model_msg();
    bit          oflow;
    logic [15:0] s;
    if (m_valid) begin
      if (m_drop < 255) m_drop++;
      return;
    end
    oflow = 0;
    s = '0;
    foreach (q_addr[i]) begin
      if (q_addr[i] >= DEPTH) oflow = 1;
      else s = s + 16'(q_data[i]);
    end
    if (cur_right && !oflow && q_addr.size() == cur_len && cur_len <= DEPTH) begin
      m_valid = 1;
      m_flag  = cur_flag;
      m_len   = 16'(cur_len);
      m_src   = cur_line;
      m_sum   = CHK ? s : 16'h0;
      for (int i = 0; i < DEPTH; i++) m_def[i] = 0;
      foreach (q_addr[i]) begin
        m_mem[q_addr[i]] = q_data[i];
        m_def[q_addr[i]] = 1;
      end
    end else if (m_err < 255) begin
      m_err++;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int unsigned a, input logic [7:0] d);
    bit got;
    wr_addr = 16'(a);
    wr_data = d;
    wr_rq   = 1'b1;
    got     = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      if (wr_rdy) got = 1;
    end
    wr_rq = 1'b0;
    check("wr_rdy_seen", 32'(got), 32'd1);
    tick();
  endtask

  task automatic send_hdr(input bit with_ack);
    hdr_flag = cur_flag;
    hdr_len  = 16'(cur_len);
    hdr_en   = 1'b1;
    msg_ack  = with_ack;
    tick();
    hdr_en   = 1'b0;
    msg_ack  = 1'b0;
  endtask

  task automatic send_end();
    msg_right = cur_right;
    msg_line  = cur_line;
    end_msg   = 1'b1;
    tick();
    end_msg   = 1'b0;
    msg_right = 1'b0;
    msg_line  = 1'b0;
  endtask

  task automatic check_state();
    check("msg_valid", 32'(msg_valid), 32'(m_valid));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (m_valid) begin
      check("msg_flag", 32'(msg_flag), 32'(m_flag));
      check("msg_len", 32'(msg_len), 32'(m_len));
      check("msg_src", 32'(msg_src), 32'(m_src));
      check("msg_sum", 32'(msg_sum), 32'(m_sum));
      for (int a = 0; a < DEPTH; a++) begin
        if (m_def[a]) begin
          rd_addr = AW'(a);
          tick();
          check("rd_data", 32'(rd_data), 32'(m_mem[a]));
        end
      end
    end
  endtask

  task automatic drive_msg(input bit with_ack);
    send_hdr(with_ack);
    foreach (q_addr[i]) do_write(q_addr[i], q_data[i]);
    send_end();
    if (with_ack) m_valid = 0;
    model_msg();
    check_state();
  endtask

  task automatic do_ack();
    msg_ack = 1'b1;
    tick();
    msg_ack = 1'b0;
    m_valid = 0;
    check("ack_clears", 32'(msg_valid), 32'd0);
  endtask

  task automatic set_msg(input int len, input int n, input logic [7:0] flag, input bit right);
    cur_len = len; cur_flag = flag; cur_right = right; cur_line = 1'($urandom);
    q_addr.delete();
    q_data.delete();
    for (int i = 0; i < n; i++) begin
      q_addr.push_back(i);
      q_data.push_back(8'($urandom));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(msg_valid), 32'd0);
    check({tag, "_rdy"}, 32'(wr_rdy), 32'd0);
    check({tag, "_len"}, 32'(msg_len), 32'd0);
    check({tag, "_flag"}, 32'(msg_flag), 32'd0);
    check({tag, "_src"}, 32'(msg_src), 32'd0);
    check({tag, "_sum"}, 32'(msg_sum), 32'd0);
    check({tag, "_rd"}, 32'(rd_data), 32'd0);
    check({tag, "_err"}, 32'(err_cnt), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    int pulses, kind, len, n, opt;
    bit rev;
    model_reset();
    tick();
    tick();
    check_reset_outputs("reset");
    rst_h = 1'b0;
    tick();

    // Basic 4-byte commit with known payload.
    set_msg(4, 4, 8'h5C, 1);
    q_data[0] = 8'h11; q_data[1] = 8'h22; q_data[2] = 8'h33; q_data[3] = 8'h44;
    drive_msg(0);
    rd_addr = AW'(2);
    tick();
    check("tp1_rd2", 32'(rd_data), 32'h33);
    check("tp1_sum", 32'(msg_sum), CHK ? 32'h00AA : 32'h0);
    check("tp1_len", 32'(msg_len), 32'd4);
    do_ack();

    // Short message is rejected.
    set_msg(4, 3, 8'h01, 1);
    drive_msg(0);
    check("tp2_err", 32'(err_cnt), 32'd1);

    // Busy buffer: second message dropped, first message intact.
    set_msg(2, 2, 8'h02, 1);
    q_data[0] = 8'hA5; q_data[1] = 8'h5A;
    drive_msg(0);
    set_msg(2, 2, 8'h03, 1);
    drive_msg(0);
    check("tp3_drop", 32'(drop_cnt), 32'd1);
    rd_addr = '0;
    tick();
    check("tp3_rd0", 32'(rd_data), 32'hA5);
    do_ack();

    // Out-of-range address: acknowledged, message rejected.
    set_msg(1, 0, 8'h04, 1);
    q_addr.push_back(DEPTH);
    q_data.push_back(8'hEE);
    drive_msg(0);

    // Held request yields a single acknowledge and one stored byte.
    set_msg(1, 1, 8'h05, 1);
    q_data[0] = 8'h77;
    send_hdr(0);
    wr_addr = '0; wr_data = 8'h77; wr_rq = 1'b1;
    pulses = 0;
    repeat (5) begin
      tick();
      if (wr_rdy) pulses++;
    end
    wr_rq = 1'b0;
    tick();
    check("hold_pulses", 32'(pulses), 32'd1);
    send_end();
    model_msg();
    check_state();

    // Ack and new header in the same cycle start reception.
    set_msg(3, 3, 8'h06, 1);
    drive_msg(1);
    do_ack();

    // Header without end is an error; the new header restarts reception.
    set_msg(3, 2, 8'h07, 1);
    send_hdr(0);
    foreach (q_addr[i]) do_write(q_addr[i], q_data[i]);
    if (m_err < 255) m_err++;
    set_msg(2, 2, 8'h08, 1);
    drive_msg(0);
    do_ack();

    // Empty message and full-depth boundary.
    set_msg(0, 0, 8'h09, 1);
    drive_msg(0);
    do_ack();
    set_msg(DEPTH, DEPTH, 8'h0A, 1);
    drive_msg(0);
    do_ack();
    set_msg(DEPTH + 1, DEPTH + 1, 8'h0B, 1);
    drive_msg(0);

    // Reset in the middle of reception.
    set_msg(3, 2, 8'h0C, 1);
    send_hdr(0);
    foreach (q_addr[i]) do_write(q_addr[i], q_data[i]);
    rst_h = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst_h = 1'b0;
    model_reset();
    tick();
    set_msg(1, 1, 8'h0D, 1);
    drive_msg(0);

    // Randomized message mix.
    for (int it = 0; it < 40; it++) begin
      if (m_valid) begin
        opt = $urandom_range(0, 3);
        if (opt >= 2) do_ack();
      end else begin
        opt = 2;
      end
      kind = $urandom_range(0, 5);
      len  = $urandom_range(0, DEPTH + 2);
      n    = len;
      if (kind == 3) n = (len > 0 && $urandom_range(0, 1) == 1) ? len - 1 : len + 1;
      set_msg(len, n, 8'($urandom), kind != 4);
      rev = 1'($urandom);
      if (rev) foreach (q_addr[i]) q_addr[i] = n - 1 - i;
      if (kind == 5 && n > 0) q_addr[n-1] = $urandom_range(DEPTH, 40);
      drive_msg(m_valid && opt == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_message_sink.md
# rx_message_sink

Receive-side buffer that terminates the RAM write interface of the high-speed protocol receiver. It acknowledges per-byte write requests and stores the payload in an internal byte RAM. It checks the byte count against the decoded header and presents one completed, correct message at a time to a local reader through a valid/ack handshake. It sits beside the transmit-side `slave_device`, between the receiver's RX_RAM_* / RX_FLAG* / RX_END_MESSAGE* outputs and the consuming logic.

## Interface
- `ADDR_W`, 10: buffer address width; depth = 2^ADDR_W bytes.
- `ERR_W`, 8: width of the saturating error/drop counters.
- `clk` in 1: system clock (`bb_clk_in` domain).
- `rst_h` in 1: reset, synchronous, active-high.
- `hdr_en` in 1: one-cycle pulse; `hdr_flag` and `hdr_len` are valid.
- `hdr_flag` in 8: message flag/status byte.
- `hdr_len` in 16: declared number of payload bytes.
- `wr_rq` in 1: write request, level; held until `wr_rdy`.
- `wr_addr` in 16: byte address within the message.
- `wr_data` in 8: byte to store.
- `wr_rdy` out 1: one-cycle acknowledge of `wr_rq`.
- `end_msg` in 1: one-cycle pulse; message reception finished.
- `msg_right` in 1: sampled with `end_msg`; 1 = receiver accepted the message.
- `msg_line` in 1: sampled with `end_msg`; 0 = COM1, 1 = COM2.
- `msg_valid` out 1: a committed message is available.
- `msg_flag` out 8, `msg_len` out 16, `msg_src` out 1: committed header and line; stable while `msg_valid`.
- `msg_sum` out 16: payload checksum (see Configuration).
- `msg_ack` in 1: reader releases the buffer.
- `rd_addr` in ADDR_W, `rd_data` out 8: reader port, 1-cycle latency.
- `err_cnt` out ERR_W: count of rejected messages.
- `drop_cnt` out ERR_W: count of messages dropped because the buffer was busy.

## Operation
- FSM states: IDLE, RECV, DROP, HOLD.
- IDLE: on `hdr_en`, latch flag and len, clear `wr_count` and `oflow`, go to RECV.
- HOLD: on `hdr_en`, increment `drop_cnt` and go to DROP.
- RECV: writes are accepted and stored at `wr_addr[ADDR_W-1:0]`; `wr_count` increments.
  - A write with `wr_addr >= 2^ADDR_W` is acknowledged but not stored, and sets `oflow`.
- DROP: writes are acknowledged and discarded.
- Write accept condition: `wr_rq && !wr_rdy` in RECV or DROP. `wr_rdy` is registered: high the cycle after accept, for exactly one cycle. Requests in IDLE/HOLD are acknowledged and discarded (no deadlock).
- RECV on `end_msg`:
  - Commit when `msg_right && !oflow && wr_count == hdr_len && hdr_len <= 2^ADDR_W`. Commit latches msg_flag, msg_len, msg_src, sets `msg_valid`, goes to HOLD.
  - Otherwise increment `err_cnt` and go to IDLE.
- DROP on `end_msg`: return to HOLD if `msg_valid`, else IDLE.
- `hdr_en` in RECV (missing end): count as error, restart RECV with the new header.
- HOLD: `msg_ack` clears `msg_valid` and returns to IDLE. `msg_ack` outside HOLD is ignored.
- `hdr_len == 0` with `msg_right`: commits an empty message.
- Counters saturate at all-ones; they are never cleared except by reset.
- `wr_count` is 17 bits and does not wrap.

## Timing
- Reset values: all outputs 0, FSM IDLE.
- `wr_rdy` 1 cycle after accept; maximum one accept per 2 cycles.
- `msg_valid` rises the cycle after `end_msg`.
- `rd_data` valid 1 cycle after `rd_addr`. Reads are allowed in any state; content is only defined in HOLD.
- Simultaneous `end_msg` and an accepted write: the write is counted first, then the commit check.
- Simultaneous `msg_ack` and `hdr_en` in HOLD: the ack wins, the header starts RECV.
- Reset mid-message: buffer content is undefined, state IDLE, `msg_valid` 0.

## Configuration
- `VSI_SINK_CHECKSUM_EN` defined:
  - `msg_sum` is the 16-bit modulo-2^16 sum of all stored payload bytes, accumulated in RECV.
  - It is cleared on `hdr_en` and latched on commit.
- Undefined: `msg_sum` is tied to 0 and the adder is absent.

## Structure
- Shared package `vsi_pkg`: FSM state enum, `VSI_LEN_W = 16`, `VSI_BYTE_W = 8`.
- One sub-module `rx_sink_ram`: simple dual-port byte RAM, synchronous write and registered read, inferable as block RAM.

## Test plan
- Header len=4, writes 0x11,0x22,0x33,0x44 at addr 0..3, `end_msg` with `msg_right`=1 -> `msg_valid`=1, msg_len=4, rd addr 2 -> 0x33, msg_sum=0x00AA (with the macro).
- Header len=4, three writes, `end_msg` -> `err_cnt`=1, `msg_valid`=0, FSM IDLE.
- Commit a message, then a second header plus 2 writes without ack -> both `wr_rdy` pulses seen, `drop_cnt`=1, rd addr 0 still returns the first message's byte.
- ADDR_W=4, write at addr 16 -> acknowledged, `end_msg` -> `err_cnt`=1.
- `wr_rq` held 5 cycles -> exactly one `wr_rdy` pulse and one stored byte.
- `rst_h` during RECV after 2 writes -> next cycle all outputs 0; a fresh len=1 message commits normally.
